hazard_controller: RTL and testbench
====================================

Name: hazard_controller

Overview:
- Pipeline sequencing controller for the 5-stage RV32 core.
- Drives the stall, flush and forward controls of the F/D, D/E (ID/EX), E/M and M/W pipeline registers.
- Resolves RAW forwarding, load-use bubbles, taken branch/jump redirects and data-memory wait states.
- Keeps a wait-state watchdog and saturating performance counters for stall and flush events.

Parameters:
- CNT_W, 32, width of each performance counter.
- WAIT_MAX, 16, consecutive memory-wait cycles before mem_timeout sets; legal range 1..255.

Ports:
- clk  in  1  clock
- reset  in  1  reset; synchronous, active-high
- rs1D  in  5  source register 1 of the instruction in D
- rs2D  in  5  source register 2 of the instruction in D
- rs1E  in  5  source register 1 of the instruction in E
- rs2E  in  5  source register 2 of the instruction in E
- rdE  in  5  destination register of the instruction in E
- rdM  in  5  destination register of the instruction in M
- rdW  in  5  destination register of the instruction in W
- ResultSrcE  in  2  result select in E; 2'b01 = load
- RegWriteM  in  1  instruction in M writes the register file
- RegWriteW  in  1  instruction in W writes the register file
- PCSrcE  in  1  taken branch or jump resolved in E
- MemAccessM  in  1  load or store in M
- dmem_ready  in  1  data memory completes the M access this cycle
- ForwardAE  out  2  ALU operand A select: 00 RD1E, 10 ALUResultM, 01 ResultW
- ForwardBE  out  2  ALU operand B select, same encoding as ForwardAE
- StallF  out  1  hold PC
- StallD  out  1  hold F/D register
- StallE  out  1  hold D/E register
- StallM  out  1  hold E/M register
- FlushD  out  1  clear F/D register
- FlushE  out  1  clear D/E register
- FlushW  out  1  clear M/W register
- mem_timeout  out  1  sticky watchdog flag
- stall_cnt  out  CNT_W  cycles with StallF=1
- flush_cnt  out  CNT_W  cycles with a redirect flush

Behaviour:
- Forwarding (combinational), per operand X in {1,2}:
  - 10 if rsXE==rdM, RegWriteM=1 and rdM!=0.
  - else 01 if rsXE==rdW, RegWriteW=1 and rdW!=0.
  - else 00. M has priority over W.
- lwStall = (ResultSrcE==2'b01) & rdE!=0 & (rdE==rs1D | rdE==rs2D).
- memWait = MemAccessM & ~dmem_ready.
- Priority, highest first:
  - memWait: StallF=StallD=StallE=StallM=1, FlushW=1, all other flushes 0. The stall completes the pending redirect or load-use when the wait ends, since E is frozen.
  - PCSrcE: FlushD=FlushE=1, no stalls. lwStall is masked because it cannot be true for a branch or jump in E.
  - lwStall: StallF=StallD=1, FlushE=1, for exactly one cycle per hazard.
  - otherwise: all controls 0.
- Control outputs are purely combinational, zero-latency, and go to 0 while reset=1.
- FSM, 2 states, registered:
  - RUN: go to WAIT when memWait.
  - WAIT: stay while memWait; go to RUN when dmem_ready=1 (that cycle is still not stalled).
- wait_cnt (8 bit): cleared in RUN, increments each WAIT cycle, saturates at WAIT_MAX.
- mem_timeout: set to 1 on the cycle wait_cnt reaches WAIT_MAX; stays set until reset.
- stall_cnt: +1 on each cycle with StallF=1; saturates at all-ones.
- flush_cnt: +1 on each cycle with PCSrcE=1 and memWait=0; saturates at all-ones.
- Reset values: state=RUN, wait_cnt=0, mem_timeout=0, stall_cnt=0, flush_cnt=0.
- Reset asserted mid-wait: FSM returns to RUN on the next edge.
- x0 is never forwarded and never triggers a stall.

Decomposition:
- Shared package hazard_pkg holds:
  - ForwardSel encodings (FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10).
  - RESULT_LOAD=2'b01.
  - FSM state typedef (ST_RUN, ST_WAIT).
- One natural sub-module: sat_counter (parameter W, inputs clk/reset/inc, output count). It is instantiated twice.

Test Plan:
- Forwarding: rs1E=5, rdM=5, RegWriteM=1, rdW=5, RegWriteW=1 -> ForwardAE=10. Then RegWriteM=0 -> ForwardAE=01. Then rdM=rdW=0 -> ForwardAE=00.
- Load-use: ResultSrcE=01, rdE=7, rs2D=7 for 1 cycle -> StallF=StallD=FlushE=1 that cycle only; stall_cnt=1.
- Branch: PCSrcE=1 for 1 cycle -> FlushD=FlushE=1, StallF=0; flush_cnt=1. With lwStall also forced -> StallF still 0.
- Memory wait: MemAccessM=1, dmem_ready=0 for 3 cycles, then 1 -> StallF/D/E/M=1 and FlushW=1 for 3 cycles; FSM back to RUN; stall_cnt=3; mem_timeout=0.
- Timeout: WAIT_MAX=4, dmem_ready held 0 for 6 cycles -> mem_timeout=1 from the 5th wait cycle. It stays 1 after dmem_ready=1 and clears only on reset.
- Reset: reset=1 during WAIT with PCSrcE=1 -> all controls 0 while reset is high; next edge gives state=RUN and all counters 0.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared encodings and helpers for the pipeline hazard controller.
package hazard_pkg;

    localparam logic [1:0] FWD_RF      = 2'b00;
    localparam logic [1:0] FWD_W       = 2'b01;
    localparam logic [1:0] FWD_M       = 2'b10;
    localparam logic [1:0] RESULT_LOAD = 2'b01;

    typedef enum logic {
        ST_RUN,
        ST_WAIT
    } hz_state_t;

    // M-stage result wins over W-stage result; x0 is never a forwarding source.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic [4:0] rd_m,
        input logic       we_m,
        input logic [4:0] rd_w,
        input logic       we_w
    );
        if (we_m && rd_m != 5'd0 && rs == rd_m)
            return FWD_M;
        else if (we_w && rd_w != 5'd0 && rs == rd_w)
            return FWD_W;
        else
            return FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_controller_if.sv
// Pipeline-to-hazard-controller signal bundle; the pipeline is master, the controller is slave.
interface hazard_controller_if #(
    parameter int unsigned CNT_W = 32
);
    logic [4:0]       rs1D;
    logic [4:0]       rs2D;
    logic [4:0]       rs1E;
    logic [4:0]       rs2E;
    logic [4:0]       rdE;
    logic [4:0]       rdM;
    logic [4:0]       rdW;
    logic [1:0]       ResultSrcE;
    logic             RegWriteM;
    logic             RegWriteW;
    logic             PCSrcE;
    logic             MemAccessM;
    logic             dmem_ready;
    logic [1:0]       ForwardAE;
    logic [1:0]       ForwardBE;
    logic             StallF;
    logic             StallD;
    logic             StallE;
    logic             StallM;
    logic             FlushD;
    logic             FlushE;
    logic             FlushW;
    logic             mem_timeout;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW, ResultSrcE,
               RegWriteM, RegWriteW, PCSrcE, MemAccessM, dmem_ready,
        input  ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
               FlushD, FlushE, FlushW, mem_timeout, stall_cnt, flush_cnt
    );

    modport slave (
        input  rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW, ResultSrcE,
               RegWriteM, RegWriteW, PCSrcE, MemAccessM, dmem_ready,
        output ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
               FlushD, FlushE, FlushW, mem_timeout, stall_cnt, flush_cnt
    );

endinterface

// File: rtl/hazard_controller_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (reset)
            count <= '0;
        else if (inc && count != '1)
            count <= count + 1'b1;
    end

endmodule

// File: rtl/hazard_controller.sv
// Stall/flush/forward sequencing for the 5-stage RV32 pipeline, with a
// memory wait-state watchdog and saturating stall/flush event counters.
module hazard_controller
    import hazard_pkg::*;
#(
    parameter int unsigned CNT_W    = 32,
    parameter int unsigned WAIT_MAX = 16
) (
    input logic                clk,
    input logic                reset,
    hazard_controller_if.slave hz
);

    localparam logic [7:0] WAIT_LIM = 8'(WAIT_MAX);

    hz_state_t  state;
    hz_state_t  state_next;
    logic       in_wait;
    logic [7:0] wait_cnt;
    logic       timeout_q;
    logic       mem_wait;
    logic       lw_stall;
    logic       flush_evt;
    logic [CNT_W-1:0] stall_count;
    logic [CNT_W-1:0] flush_count;

    assign mem_wait = hz.MemAccessM & ~hz.dmem_ready;
    assign lw_stall = (hz.ResultSrcE == RESULT_LOAD) && (hz.rdE != 5'd0) &&
                      ((hz.rdE == hz.rs1D) || (hz.rdE == hz.rs2D));

    always_comb begin
        hz.ForwardAE = FWD_RF;
        hz.ForwardBE = FWD_RF;
        if (!reset) begin
            hz.ForwardAE = fwd_sel(hz.rs1E, hz.rdM, hz.RegWriteM, hz.rdW, hz.RegWriteW);
            hz.ForwardBE = fwd_sel(hz.rs2E, hz.rdM, hz.RegWriteM, hz.rdW, hz.RegWriteW);
        end
    end

    // A memory wait freezes F..M, so any redirect or load-use in E is replayed once it ends.
    always_comb begin
        hz.StallF = 1'b0;
        hz.StallD = 1'b0;
        hz.StallE = 1'b0;
        hz.StallM = 1'b0;
        hz.FlushD = 1'b0;
        hz.FlushE = 1'b0;
        hz.FlushW = 1'b0;
        if (!reset) begin
            if (mem_wait) begin
                hz.StallF = 1'b1;
                hz.StallD = 1'b1;
                hz.StallE = 1'b1;
                hz.StallM = 1'b1;
                hz.FlushW = 1'b1;
            end else if (hz.PCSrcE) begin
                hz.FlushD = 1'b1;
                hz.FlushE = 1'b1;
            end else if (lw_stall) begin
                hz.StallF = 1'b1;
                hz.StallD = 1'b1;
                hz.FlushE = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= ST_RUN;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_RUN:  if (mem_wait) state_next = ST_WAIT;
            ST_WAIT: if (!mem_wait) state_next = ST_RUN;
            default: state_next = ST_RUN;
        endcase
    end

    always_comb begin
        in_wait = (state == ST_WAIT);
    end

    always_ff @(posedge clk) begin
        if (reset || !in_wait)
            wait_cnt <= '0;
        else if (wait_cnt != WAIT_LIM)
            wait_cnt <= wait_cnt + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (reset)
            timeout_q <= 1'b0;
        else if (in_wait && wait_cnt == WAIT_LIM - 8'd1)
            timeout_q <= 1'b1;
    end

    assign hz.mem_timeout = timeout_q;
    assign flush_evt      = hz.PCSrcE & ~mem_wait & ~reset;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (hz.StallF),
        .count (stall_count)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (flush_evt),
        .count (flush_count)
    );

    assign hz.stall_cnt = stall_count;
    assign hz.flush_cnt = flush_count;

endmodule

// File: tb/tb_hazard_controller.sv
// Directed checks of forwarding, stall/flush priority, watchdog and counters.
module tb_hazard_controller;

    localparam int unsigned CW = 4;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    hazard_controller_if #(.CNT_W(CW)) hz ();

    hazard_controller #(.CNT_W(CW), .WAIT_MAX(4)) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}
    function automatic logic [31:0] ctl();
        return {25'd0, hz.StallF, hz.StallD, hz.StallE, hz.StallM,
                hz.FlushD, hz.FlushE, hz.FlushW};
    endfunction

    initial begin
        reset = 1'b1;
        hz.rs1D = '0; hz.rs2D = '0; hz.rs1E = '0; hz.rs2E = '0;
        hz.rdE = '0; hz.rdM = '0; hz.rdW = '0; hz.ResultSrcE = '0;
        hz.RegWriteM = 1'b0; hz.RegWriteW = 1'b0; hz.PCSrcE = 1'b0;
        hz.MemAccessM = 1'b0; hz.dmem_ready = 1'b1;
        cyc(); cyc();
        check("rst_ctl", ctl(), 32'h00);
        check("rst_stall_cnt", 32'(hz.stall_cnt), 32'd0);
        check("rst_flush_cnt", 32'(hz.flush_cnt), 32'd0);
        check("rst_timeout", 32'(hz.mem_timeout), 32'd0);
        reset = 1'b0;

        // forwarding priority and x0
        hz.rs1E = 5'd5; hz.rdM = 5'd5; hz.RegWriteM = 1'b1; hz.rdW = 5'd5; hz.RegWriteW = 1'b1;
        #1 check("fwdA_M", 32'(hz.ForwardAE), 32'h2);
        hz.RegWriteM = 1'b0;
        #1 check("fwdA_W", 32'(hz.ForwardAE), 32'h1);
        hz.rdM = 5'd0; hz.rdW = 5'd0;
        #1 check("fwdA_RF", 32'(hz.ForwardAE), 32'h0);
        hz.rs2E = 5'd0; hz.RegWriteM = 1'b1;
        #1 check("fwdB_x0", 32'(hz.ForwardBE), 32'h0);
        hz.rs2E = 5'd9; hz.rdW = 5'd9; hz.rdM = 5'd9; hz.RegWriteM = 1'b0;
        #1 check("fwdB_W", 32'(hz.ForwardBE), 32'h1);
        hz.RegWriteM = 1'b1;
        #1 check("fwdB_M", 32'(hz.ForwardBE), 32'h2);
        hz.rs1E = '0; hz.rs2E = '0; hz.rdM = '0; hz.rdW = '0;
        hz.RegWriteM = 1'b0; hz.RegWriteW = 1'b0;

        // load-use bubble
        hz.ResultSrcE = 2'b01; hz.rdE = 5'd7; hz.rs2D = 5'd7;
        #1 check("lw_ctl", ctl(), 32'b1100010);
        cyc();
        hz.ResultSrcE = 2'b00;
        #1 check("lw_clear", ctl(), 32'h00);
        check("lw_stall_cnt", 32'(hz.stall_cnt), 32'd1);
        hz.ResultSrcE = 2'b01; hz.rdE = 5'd0; hz.rs1D = 5'd0; hz.rs2D = 5'd3;
        #1 check("lw_x0", ctl(), 32'h00);
        hz.ResultSrcE = 2'b00;

        // taken branch, with load-use also asserted
        hz.PCSrcE = 1'b1; hz.ResultSrcE = 2'b01; hz.rdE = 5'd7; hz.rs2D = 5'd7;
        #1 check("br_ctl", ctl(), 32'b0000110);
        cyc();
        hz.PCSrcE = 1'b0; hz.ResultSrcE = 2'b00; hz.rdE = '0; hz.rs2D = '0;
        #1 check("br_flush_cnt", 32'(hz.flush_cnt), 32'd1);
        check("br_stall_cnt", 32'(hz.stall_cnt), 32'd1);

        // memory wait of three cycles; redirect during wait is held off
        hz.MemAccessM = 1'b1; hz.dmem_ready = 1'b0; hz.PCSrcE = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 check("mw_ctl", ctl(), 32'b1111001);
            cyc();
        end
        hz.dmem_ready = 1'b1; hz.PCSrcE = 1'b0;
        #1 check("mw_done_ctl", ctl(), 32'h00);
        check("mw_stall_cnt", 32'(hz.stall_cnt), 32'd4);
        check("mw_flush_cnt", 32'(hz.flush_cnt), 32'd1);
        cyc();
        hz.MemAccessM = 1'b0;
        check("mw_timeout", 32'(hz.mem_timeout), 32'd0);

        // watchdog with WAIT_MAX=4: flag visible from the 5th wait cycle
        hz.MemAccessM = 1'b1; hz.dmem_ready = 1'b0;
        cyc(); cyc(); cyc(); cyc();
        check("to_not_yet", 32'(hz.mem_timeout), 32'd0);
        cyc();
        check("to_set", 32'(hz.mem_timeout), 32'd1);
        cyc();
        hz.dmem_ready = 1'b1;
        cyc();
        hz.MemAccessM = 1'b0;
        cyc();
        check("to_sticky", 32'(hz.mem_timeout), 32'd1);
        check("to_stall_cnt", 32'(hz.stall_cnt), 32'd10);

        // stall counter saturates at all-ones
        hz.ResultSrcE = 2'b01; hz.rdE = 5'd4; hz.rs1D = 5'd4;
        for (int i = 0; i < 8; i++) cyc();
        hz.ResultSrcE = 2'b00;
        check("stall_sat", 32'(hz.stall_cnt), 32'd15);

        // reset in the middle of a wait with a redirect pending
        hz.MemAccessM = 1'b1; hz.dmem_ready = 1'b0;
        cyc(); cyc();
        reset = 1'b1; hz.PCSrcE = 1'b1;
        #1 check("rst_mid_ctl", ctl(), 32'h00);
        check("rst_mid_fwd", 32'({hz.ForwardAE, hz.ForwardBE}), 32'h0);
        cyc();
        check("rst_mid_stall_cnt", 32'(hz.stall_cnt), 32'd0);
        check("rst_mid_flush_cnt", 32'(hz.flush_cnt), 32'd0);
        check("rst_mid_timeout", 32'(hz.mem_timeout), 32'd0);
        reset = 1'b0; hz.PCSrcE = 1'b0;
        #1 check("post_rst_ctl", ctl(), 32'b1111001);
        // starting from RUN, the flag needs five edges again
        cyc(); cyc(); cyc(); cyc();
        check("post_rst_to_not_yet", 32'(hz.mem_timeout), 32'd0);
        cyc();
        check("post_rst_to_set", 32'(hz.mem_timeout), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
